// File: rtl/eth_src_arbiter.sv
// Round-robin arbiter that lets NUM_SRC byte producers share one session write port.
// One burst per grant: o_wr is held high for the whole burst, with a forced wr-low gap afterwards.
//
// state | meaning
// IDLE  | no owner; pick the next requester at or after rr_ptr
// XFER  | owner streams bytes; o_wr high; idle timeout armed
// CLOSE | o_wr low for GAP_CYCLES so the session closes the trailing PDU
module eth_src_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int SRC_W      = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_SRC-1:0]   i_req,
    input  logic [NUM_SRC-1:0]   i_valid,
    input  logic [NUM_SRC-1:0]   i_last,
    input  logic [NUM_SRC*8-1:0] i_data,
    output logic [NUM_SRC-1:0]   o_ready,
    output logic [NUM_SRC-1:0]   o_grant,
    output logic [SRC_W-1:0]     o_src_id,
    output logic                 o_wr,
    output logic                 o_din,
    output logic [7:0]           o_data,
    input  logic                 i_full,
    output logic                 o_busy,
    output logic                 o_abort
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [SRC_W-1:0]    src_id_q, src_id_d;
    logic                abort_q, abort_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic                win_found;
    logic [SRC_W-1:0]    win_idx;
    logic [SRC_W-1:0]    rr_nxt;
    logic                in_xfer;
    logic                cur_valid;
    logic                cur_last;
    logic                xfer;

    // Search upward from rr_ptr with wrap; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!win_found && i_req[(int'(rr_ptr_q) + k) % NUM_SRC]) begin
                win_found = 1'b1;
                win_idx   = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
            end
        end
        rr_nxt = (int'(win_idx) == NUM_SRC - 1) ? '0 : win_idx + 1'b1;
    end

    assign in_xfer   = (state_q == XFER);
    assign cur_valid = i_valid[src_id_q];
    assign cur_last  = i_last[src_id_q];
    assign xfer      = in_xfer & cur_valid & ~i_full;

    assign o_ready  = xfer ? (NUM_SRC'(1) << src_id_q) : '0;
    assign o_din    = xfer;
    assign o_data   = in_xfer ? i_data[{src_id_q, 3'b000} +: 8] : 8'h00;
    assign o_wr     = in_xfer;
    assign o_busy   = (state_q != IDLE);
    assign o_grant  = grant_q;
    assign o_src_id = src_id_q;
    assign o_abort  = abort_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        src_id_d   = src_id_q;
        abort_d    = 1'b0;
        idle_cnt_d = idle_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = XFER;
                    grant_d    = NUM_SRC'(1) << win_idx;
                    src_id_d   = win_idx;
                    rr_ptr_d   = rr_nxt;
                    idle_cnt_d = '0;
                end
            end
            XFER: begin
                if (xfer && cur_last) begin
                    state_d   = CLOSE;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                end else if (xfer) begin
                    idle_cnt_d = '0;
                end else if (!i_full && !cur_valid && (TIMEOUT != 0)) begin
                    // A downstream stall (i_full) freezes the count rather than advancing it.
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d   = CLOSE;
                        grant_d   = '0;
                        gap_cnt_d = '0;
                        abort_d   = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            CLOSE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            src_id_q   <= '0;
            abort_q    <= 1'b0;
            idle_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            src_id_q   <= src_id_d;
            abort_q    <= abort_d;
            idle_cnt_q <= idle_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_src_arbiter.sv
// Directed bench for eth_src_arbiter (4 sources, 2-cycle gap, timeout of 8 idle cycles).
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
module tb_eth_src_arbiter;

    localparam int NS = 4;

    logic          clk;
    logic          rst;
    logic [NS-1:0] req, valid, last;
    logic [NS*8-1:0] data;
    logic [NS-1:0] ready, grant;
    logic [1:0]    src_id;
    logic          wr, din, full, busy, abort;
    logic [7:0]    dout;

    int n_checks = 0;
    int n_errors = 0;

    eth_src_arbiter #(
        .NUM_SRC(NS), .SRC_W(2), .GAP_CYCLES(2), .TIMEOUT(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_valid(valid), .i_last(last),
        .i_data(data), .o_ready(ready), .o_grant(grant), .o_src_id(src_id),
        .o_wr(wr), .o_din(din), .o_data(dout), .i_full(full), .o_busy(busy),
        .o_abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; valid = '0; last = '0; data = '0; full = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input int src);
        int cyc;
        cyc = 0;
        while (grant == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk(tag, grant, 32'(1 << src));
        chk({tag, "_id"}, src_id, src);
    endtask

    // Streams n bytes base, base+1, ... from src; optionally stalls with i_full before byte stall_at.
    task automatic burst(input string tag, input int src, input int n, input logic [7:0] base,
                         input bit with_last, input int stall_at, input int stall_cyc);
        int bad;
        logic [7:0] b;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            valid = '0; last = '0; data = '0;
            valid[src] = 1'b1;
            last[src]  = with_last && (i == n - 1);
            data[src*8 +: 8] = b;
            if (i == stall_at) begin
                full = 1'b1;
                for (int s = 0; s < stall_cyc; s++) begin
                    #1;
                    if (din || ready != '0 || abort || !wr) bad++;
                    tick();
                end
                full = 1'b0;
            end
            #1;
            if (!din || dout != b || ready != NS'(1 << src) || !wr) bad++;
            tick();
        end
        valid = '0; last = '0; data = '0;
        chk(tag, 32'(bad), 0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        req = '0; valid = '0; last = '0; data = '0; full = 1'b0;
        tick();
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_src_id", src_id, 0);
        chk("rst_wr", wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        chk("rst_ready", ready, 0);
        chk("rst_din", din, 0);
        chk("rst_data", dout, 0);
        rst = 1'b0;
        tick();

        // 1: single source, 1-cycle grant latency, 3 wr-low cycles between bursts
        do_reset();
        req = 4'b0010;
        #1;
        chk("t1_grant_pre", grant, 0);
        tick();
        chk("t1_grant", grant, 4'b0010);
        chk("t1_src_id", src_id, 1);
        chk("t1_wr", wr, 1);
        burst("t1_bytes", 1, 5, 8'h11, 1'b1, -1, 0);
        chk("t1_wr_gap0", wr, 0);
        chk("t1_grant_gap0", grant, 0);
        chk("t1_src_hold", src_id, 1);
        chk("t1_busy_close", busy, 1);
        tick();
        chk("t1_wr_gap1", wr, 0);
        tick();
        chk("t1_wr_gap2", wr, 0);
        chk("t1_busy_idle", busy, 0);
        tick();
        chk("t1_wr_regrant", wr, 1);
        chk("t1_regrant", grant, 4'b0010);
        req = '0;
        burst("t1_bytes2", 1, 1, 8'h20, 1'b1, -1, 0);

        // 2: all four request; round-robin order with wrap back to 0
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant($sformatf("t2_grant%0d", i), i % NS);
            if (i == 4) req = '0;
            burst($sformatf("t2_byte%0d", i), i % NS, 1, 8'(8'h40 + i), 1'b1, -1, 0);
        end

        // 3: 20-cycle downstream stall mid-burst, no timeout, all bytes delivered
        do_reset();
        req = 4'b0100;
        wait_grant("t3_grant", 2);
        req = '0;
        burst("t3_bytes", 2, 10, 8'hA0, 1'b1, 4, 20);
        chk("t3_wr_end", wr, 0);
        chk("t3_abort", abort, 0);

        // 4: idle owner is aborted after 8 idle cycles; next requester served
        do_reset();
        req = 4'b0001;
        wait_grant("t4_grant", 0);
        req = 4'b1000;
        burst("t4_bytes", 0, 2, 8'h50, 1'b0, -1, 0);
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (abort) begin
                k = c;
                break;
            end
        end
        chk("t4_abort_delay", 32'(k), 8);
        chk("t4_wr_close", wr, 0);
        chk("t4_busy_close", busy, 1);
        tick();
        chk("t4_abort_pulse", abort, 0);
        wait_grant("t4_next", 3);
        req = '0;
        burst("t4_next_byte", 3, 1, 8'h60, 1'b1, -1, 0);

        // 5: async reset in the middle of byte 3 of 6
        do_reset();
        req = 4'b0100;
        wait_grant("t5_grant", 2);
        req = '0;
        burst("t5_bytes", 2, 2, 8'h30, 1'b0, -1, 0);
        valid[2] = 1'b1;
        data[2*8 +: 8] = 8'h32;
        #1;
        chk("t5_din_pre", din, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_wr_rst", wr, 0);
        chk("t5_grant_rst", grant, 0);
        chk("t5_din_rst", din, 0);
        chk("t5_busy_rst", busy, 0);
        tick();
        rst = 1'b0;
        valid = '0; data = '0;
        req = 4'b1010;
        tick();
        chk("t5_rrptr_reset", grant, 4'b0010);
        req = '0;
        burst("t5_after", 1, 1, 8'h70, 1'b1, -1, 0);

        // 6: long burst of 1471 bytes with wr continuous throughout
        do_reset();
        req = 4'b0010;
        wait_grant("t6_grant", 1);
        req = '0;
        burst("t6_bytes", 1, 1471, 8'h00, 1'b1, -1, 0);
        chk("t6_wr_end", wr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
